// File: rtl/cnn_window_gen.sv
// Streaming KX x KY sliding-window generator (stride 1, no padding) feeding the
// CNN core's input feature-map bus; one window per accepted pixel once filled.
module cnn_window_gen #(
  parameter int CI     = 1,
  parameter int KX     = 3,
  parameter int KY     = 3,
  parameter int I_F_BW = 8,
  parameter int IX     = 28,
  parameter int IY     = 28
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_in_valid,
  input  logic [CI*I_F_BW-1:0]          i_in_pixel,
  output logic                          o_ot_valid,
  output logic [CI*KX*KY*I_F_BW-1:0]    o_ot_fmap,
  output logic                          o_ot_last,
  output logic                          o_frame_done
);

  localparam int PW  = CI * I_F_BW;
  localparam int FW  = PW * KX * KY;
  localparam int CW  = (IX > 1) ? $clog2(IX) : 1;
  localparam int RW  = (IY > 1) ? $clog2(IY) : 1;
  localparam int NLB = (KY > 1) ? KY - 1 : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IX - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IY - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(KX - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(KY - 1);

  logic          accept;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic [FW-1:0] fmap_q, fmap_d;

  logic [PW-1:0] win_q [KY][KX];
  logic [PW-1:0] win_d [KY][KX];
  logic [PW-1:0] lb_rd [NLB];

  // A pixel offered in the same cycle as reset is dropped, so it must not
  // touch the line buffers or the window either.
  always_comb begin
    accept = i_in_valid & ~reset;
  end

  // Cascaded row stores: each stage takes the previous stage's old entry at
  // the same column, so stage k holds the row k+1 above the current one.
  for (genvar k = 0; k < NLB; k++) begin : g_lb
    logic [PW-1:0] mem_q [IX];
    logic [PW-1:0] wdata;

    if (k == 0) begin : g_head
      assign wdata = i_in_pixel;
    end else begin : g_tail
      assign wdata = lb_rd[k-1];
    end

    always_ff @(posedge clk) begin
      if (accept) begin
        mem_q[col_q] <= wdata;
      end
    end

    assign lb_rd[k] = mem_q[col_q];
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int unsigned ky = 0; ky < KY; ky++) begin
        for (int unsigned kx = 0; kx + 1 < KX; kx++) begin
          win_d[ky][kx] = win_q[ky][kx+1];
        end
      end
      win_d[KY-1][KX-1] = i_in_pixel;
      for (int unsigned k = 1; k < KY; k++) begin
        win_d[KY-1-k][KX-1] = lb_rd[k-1];
      end
    end
  end

  // The emitted vector is packed from win_d so the window completed by the
  // accepting pixel appears one cycle later without an extra register stage.
  always_comb begin
    valid_d = accept && (row_q >= ROW_MIN) && (col_q >= COL_MIN);
    last_d  = accept && (row_q == ROW_LAST) && (col_q == COL_LAST);
    done_d  = last_d;
    fmap_d  = fmap_q;
    if (valid_d) begin
      for (int unsigned c = 0; c < CI; c++) begin
        for (int unsigned ky = 0; ky < KY; ky++) begin
          for (int unsigned kx = 0; kx < KX; kx++) begin
            fmap_d[((c*KY + ky)*KX + kx)*I_F_BW +: I_F_BW] =
              win_d[ky][kx][c*I_F_BW +: I_F_BW];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      fmap_q  <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      fmap_q  <= fmap_d;
    end
  end

  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  always_comb begin
    o_ot_valid   = valid_q;
    o_ot_last    = last_q;
    o_frame_done = done_q;
    o_ot_fmap    = fmap_q;
  end

endmodule

// File: tb/tb_cnn_window_gen.sv
// Directed bench for cnn_window_gen: 5x5 single-channel, 5x5 dual-channel and
// minimal 3x3 geometries, each checked cycle by cycle against expected windows.
module tb_cnn_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic va, vb, vc;
  logic [7:0]  pa, pc;
  logic [15:0] pb;
  logic ova, ola, oda, ovb, olb, odb, ovc, olc, odc;
  logic [71:0]  fa, fc;
  logic [143:0] fb;

  int errors = 0;
  int checks = 0;

  cnn_window_gen #(.CI(1), .KX(3), .KY(3), .I_F_BW(8), .IX(5), .IY(5)) dut_a (
    .clk(clk), .reset(reset), .i_in_valid(va), .i_in_pixel(pa),
    .o_ot_valid(ova), .o_ot_fmap(fa), .o_ot_last(ola), .o_frame_done(oda));

  cnn_window_gen #(.CI(2), .KX(3), .KY(3), .I_F_BW(8), .IX(5), .IY(5)) dut_b (
    .clk(clk), .reset(reset), .i_in_valid(vb), .i_in_pixel(pb),
    .o_ot_valid(ovb), .o_ot_fmap(fb), .o_ot_last(olb), .o_frame_done(odb));

  cnn_window_gen #(.CI(1), .KX(3), .KY(3), .I_F_BW(8), .IX(3), .IY(3)) dut_c (
    .clk(clk), .reset(reset), .i_in_valid(vc), .i_in_pixel(pc),
    .o_ot_valid(ovc), .o_ot_fmap(fc), .o_ot_last(olc), .o_frame_done(odc));

  // Expected 3x3 window ending at (r,c): element (ky,kx) = sgn*(base + pixel index).
  function automatic logic [71:0] exp_win(input int base, input int sgn, input int w,
                                          input int r, input int c);
    logic [71:0] res;
    int v;
    res = '0;
    for (int ky = 0; ky < 3; ky++) begin
      for (int kx = 0; kx < 3; kx++) begin
        v = sgn * (base + (r - 2 + ky) * w + (c - 2 + kx));
        res[(ky*3 + kx)*8 +: 8] = v[7:0];
      end
    end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    va = 1'b1; pa = 8'h55;
    vb = 1'b1; pb = 16'hAA55;
    vc = 1'b1; pc = 8'h33;
    tick();
    tick();
    checks++;
    if ({ova, ola, oda} !== 3'b000) begin
      errors++; $display("FAIL reset_a_flags got=%b exp=000", {ova, ola, oda});
    end
    checks++;
    if (fa !== 72'h0) begin
      errors++; $display("FAIL reset_a_fmap got=%h exp=0", fa);
    end
    checks++;
    if ({ovb, olb, odb} !== 3'b000 || fb !== 144'h0) begin
      errors++; $display("FAIL reset_b got=%b/%h exp=000/0", {ovb, olb, odb}, fb);
    end
    checks++;
    if ({ovc, olc, odc} !== 3'b000 || fc !== 72'h0) begin
      errors++; $display("FAIL reset_c got=%b/%h exp=000/0", {ovc, olc, odc}, fc);
    end
    reset = 1'b0;
    va = 1'b0; vb = 1'b0; vc = 1'b0;
    tick();
  endtask

  task automatic test_continuous();
    int nwin = 0;
    logic ev, el;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        int p = r * 5 + c;
        va = 1'b1; pa = p[7:0];
        tick();
        ev = (r >= 2 && c >= 2);
        el = (r == 4 && c == 4);
        checks++;
        if (ova !== ev) begin
          errors++; $display("FAIL cont_valid r=%0d c=%0d got=%b exp=%b", r, c, ova, ev);
        end
        if (ev) begin
          checks++;
          if (fa !== exp_win(0, 1, 5, r, c)) begin
            errors++; $display("FAIL cont_fmap r=%0d c=%0d got=%h exp=%h", r, c, fa, exp_win(0, 1, 5, r, c));
          end
          checks++;
          if ({ola, oda} !== {el, el}) begin
            errors++; $display("FAIL cont_last r=%0d c=%0d got=%b exp=%b", r, c, {ola, oda}, {el, el});
          end
        end
        if (r == 2 && c == 2) begin
          checks++;
          if (fa !== 72'h0C0B0A070605020100) begin
            errors++; $display("FAIL cont_first got=%h exp=0c0b0a070605020100", fa);
          end
        end
        if (el) begin
          checks++;
          if (fa !== 72'h1817161312110E0D0C) begin
            errors++; $display("FAIL cont_lastwin got=%h exp=1817161312110e0d0c", fa);
          end
        end
        if (ova) nwin++;
      end
    end
    va = 1'b0;
    tick();
    checks++;
    if ({ova, ola, oda} !== 3'b000) begin
      errors++; $display("FAIL cont_pulse_width got=%b exp=000", {ova, ola, oda});
    end
    checks++;
    if (nwin !== 9) begin
      errors++; $display("FAIL cont_count got=%0d exp=9", nwin);
    end
  endtask

  task automatic test_gaps();
    int nwin = 0;
    logic ev, el;
    logic [71:0] hold = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        int p = r * 5 + c;
        va = 1'b1; pa = p[7:0];
        tick();
        ev = (r >= 2 && c >= 2);
        el = (r == 4 && c == 4);
        checks++;
        if (ova !== ev || {ola, oda} !== {el, el}) begin
          errors++; $display("FAIL gap_valid r=%0d c=%0d got=%b exp=%b", r, c, {ova, ola, oda}, {ev, el, el});
        end
        if (ev) begin
          hold = exp_win(0, 1, 5, r, c);
          checks++;
          if (fa !== hold) begin
            errors++; $display("FAIL gap_fmap r=%0d c=%0d got=%h exp=%h", r, c, fa, hold);
          end
          nwin++;
        end
        for (int g = 0; g < 2; g++) begin
          va = 1'b0; pa = 8'hEE;
          tick();
          checks++;
          if ({ova, ola, oda} !== 3'b000) begin
            errors++; $display("FAIL gap_idle r=%0d c=%0d got=%b exp=000", r, c, {ova, ola, oda});
          end
          if (nwin > 0) begin
            checks++;
            if (fa !== hold) begin
              errors++; $display("FAIL gap_hold r=%0d c=%0d got=%h exp=%h", r, c, fa, hold);
            end
          end
        end
      end
    end
    checks++;
    if (nwin !== 9) begin
      errors++; $display("FAIL gap_count got=%0d exp=9", nwin);
    end
  endtask

  task automatic test_back_to_back();
    int nwin = 0;
    logic ev, el;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          int p = f * 100 + r * 5 + c;
          va = 1'b1; pa = p[7:0];
          tick();
          ev = (r >= 2 && c >= 2);
          el = (r == 4 && c == 4);
          checks++;
          if (ova !== ev || {ola, oda} !== {el, el}) begin
            errors++; $display("FAIL b2b_valid f=%0d r=%0d c=%0d got=%b exp=%b", f, r, c, {ova, ola, oda}, {ev, el, el});
          end
          if (ev) begin
            checks++;
            if (fa !== exp_win(f * 100, 1, 5, r, c)) begin
              errors++; $display("FAIL b2b_fmap f=%0d r=%0d c=%0d got=%h exp=%h", f, r, c, fa, exp_win(f * 100, 1, 5, r, c));
            end
          end
          if (f == 1 && r == 2 && c == 2) begin
            checks++;
            if (fa !== 72'h706F6E6B6A69666564) begin
              errors++; $display("FAIL b2b_first2 got=%h exp=706f6e6b6a69666564", fa);
            end
          end
          if (ova) nwin++;
        end
      end
    end
    va = 1'b0;
    tick();
    checks++;
    if (nwin !== 18) begin
      errors++; $display("FAIL b2b_count got=%0d exp=18", nwin);
    end
  endtask

  task automatic test_reset_mid_frame();
    int nwin = 0;
    logic ev, el;
    for (int i = 0; i < 13; i++) begin
      va = 1'b1; pa = i[7:0];
      tick();
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      va = 1'b1; pa = 8'h4D;
      tick();
      checks++;
      if ({ova, ola, oda} !== 3'b000 || fa !== 72'h0) begin
        errors++; $display("FAIL mid_reset cyc=%0d got=%b/%h exp=000/0", i, {ova, ola, oda}, fa);
      end
    end
    reset = 1'b0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        int p = r * 5 + c;
        va = 1'b1; pa = p[7:0];
        tick();
        ev = (r >= 2 && c >= 2);
        el = (r == 4 && c == 4);
        checks++;
        if (ova !== ev || {ola, oda} !== {el, el}) begin
          errors++; $display("FAIL mid_valid r=%0d c=%0d got=%b exp=%b", r, c, {ova, ola, oda}, {ev, el, el});
        end
        if (ev) begin
          checks++;
          if (fa !== exp_win(0, 1, 5, r, c)) begin
            errors++; $display("FAIL mid_fmap r=%0d c=%0d got=%h exp=%h", r, c, fa, exp_win(0, 1, 5, r, c));
          end
        end
        if (ova) nwin++;
      end
    end
    va = 1'b0;
    tick();
    checks++;
    if (nwin !== 9) begin
      errors++; $display("FAIL mid_count got=%0d exp=9", nwin);
    end
  endtask

  task automatic test_channels();
    int nwin = 0;
    logic ev, el;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        int p = r * 5 + c;
        int n = -p;
        vb = 1'b1; pb = {n[7:0], p[7:0]};
        tick();
        ev = (r >= 2 && c >= 2);
        el = (r == 4 && c == 4);
        checks++;
        if (ovb !== ev || {olb, odb} !== {el, el}) begin
          errors++; $display("FAIL ch_valid r=%0d c=%0d got=%b exp=%b", r, c, {ovb, olb, odb}, {ev, el, el});
        end
        if (ev) begin
          checks++;
          if (fb !== {exp_win(0, -1, 5, r, c), exp_win(0, 1, 5, r, c)}) begin
            errors++; $display("FAIL ch_fmap r=%0d c=%0d got=%h exp=%h", r, c, fb,
                               {exp_win(0, -1, 5, r, c), exp_win(0, 1, 5, r, c)});
          end
        end
        if (r == 2 && c == 2) begin
          checks++;
          if (fb !== 144'hF4F5F6F9FAFBFEFF000C0B0A070605020100) begin
            errors++; $display("FAIL ch_first got=%h exp=f4f5f6f9fafbfeff000c0b0a070605020100", fb);
          end
        end
        if (ovb) nwin++;
      end
    end
    vb = 1'b0;
    tick();
    checks++;
    if (nwin !== 9) begin
      errors++; $display("FAIL ch_count got=%0d exp=9", nwin);
    end
  endtask

  task automatic test_edge_geometry();
    int nwin = 0;
    for (int i = 0; i < 9; i++) begin
      vc = 1'b1; pc = i[7:0];
      tick();
      checks++;
      if (ovc !== (i == 8) || {olc, odc} !== {(i == 8), (i == 8)}) begin
        errors++; $display("FAIL edge_valid i=%0d got=%b exp=%b", i, {ovc, olc, odc}, {3{i == 8}});
      end
      if (ovc) nwin++;
    end
    checks++;
    if (fc !== 72'h080706050403020100) begin
      errors++; $display("FAIL edge_fmap got=%h exp=080706050403020100", fc);
    end
    vc = 1'b0;
    tick();
    checks++;
    if ({ovc, olc, odc} !== 3'b000 || nwin !== 1) begin
      errors++; $display("FAIL edge_after got=%b n=%0d exp=000 n=1", {ovc, olc, odc}, nwin);
    end
  endtask

  initial begin
    reset = 1'b0;
    va = 1'b0; vb = 1'b0; vc = 1'b0;
    pa = '0; pb = '0; pc = '0;
    test_reset();
    test_continuous();
    test_gaps();
    test_back_to_back();
    test_reset_mid_frame();
    test_channels();
    test_edge_geometry();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnn_window_gen.md
# cnn_window_gen

Streaming sliding-window generator that sits directly upstream of the CNN core. It accepts one CI-channel pixel per valid cycle in raster order and buffers KY-1 image rows plus KX columns. For every input pixel that completes a full KX x KY neighbourhood, it emits that neighbourhood as one flat window vector, packed exactly as the core's input feature-map bus expects. Stride is 1 and there is no padding, so each frame yields (IX-KX+1)*(IY-KY+1) windows.

## Interface
- CI, 1: input channels per pixel
- KX, 3: kernel width
- KY, 3: kernel height
- I_F_BW, 8: bits per channel sample (signed, passed through unmodified)
- IX, 28: image width in pixels (IX >= KX)
- IY, 28: image height in pixels (IY >= KY)

- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i_in_valid  in  1  qualifies i_in_pixel for this cycle
- i_in_pixel  in  CI*I_F_BW  one pixel; channel c at bits [c*I_F_BW +: I_F_BW]
- o_ot_valid  out  1  window valid, one-cycle pulse per window
- o_ot_fmap  out  CI*KX*KY*I_F_BW  window vector, feeds the core's i_in_fmap
- o_ot_last  out  1  high together with o_ot_valid on the last window of a frame
- o_frame_done  out  1  one-cycle pulse registered on acceptance of the last pixel of a frame

## Operation
- Pixels arrive in raster order: col 0..IX-1 within a row, then row 0..IY-1. A pixel is accepted only when i_in_valid=1. Gaps of any length are allowed and stall all state.
- There is no backpressure. The downstream stage must accept every o_ot_valid pulse.
- Counters col ($clog2(IX) bits) and row ($clog2(IY) bits) advance on each accepted pixel. col wraps at IX-1 and increments row; row wraps at IY-1 back to 0. The next frame starts immediately with no idle cycle needed.
- Line buffer: KY-1 row stores, each IX deep x CI*I_F_BW wide, indexed by col. Stores are cascaded: on acceptance, store[k] at col is written with the old store[k-1] at col, and store[0] is written with the new pixel. Implementation may use registers or inferred RAM with read-before-write semantics at the same address.
- Window register: KY rows x KX columns. On acceptance every row shifts one column toward kx=0. The new kx=KX-1 column is filled as follows:
  - ky=KY-1: the incoming pixel.
  - ky=KY-1-k (k >= 1): store[k-1] at col, read before the write.
- Window element (ky,kx) equals the input pixel at (row-KY+1+ky, col-KX+1+kx) of the accepting cycle. ky=0 is the oldest row and kx=0 the oldest column.
- Packing: channel c of element (ky,kx) is placed at bit offset (((c*KY)+ky)*KX+kx)*I_F_BW.
- Emit condition (evaluated on the accepting cycle): row >= KY-1 and col >= KX-1. Only then does o_ot_valid assert on the next cycle.
- o_ot_last is asserted with the window emitted for row=IY-1, col=IX-1.
- o_ot_fmap holds its last value when o_ot_valid=0. Its content is don't-care before the first window.
- Stale line-buffer contents from a previous frame or from before a reset are never emitted. The emit condition guarantees every window element was written in the current frame. Line buffers therefore need no reset.

## Timing
- Latency: 1 cycle from the accepting clk edge to o_ot_valid/o_ot_fmap. o_frame_done is co-timed with o_ot_last.
- Throughput: one window per clock when i_in_valid is held high.
- Reset (reset=1 at an edge) sets col=0, row=0, o_ot_valid=0, o_ot_last=0, o_frame_done=0, and o_ot_fmap=0.
  - Reset mid-frame discards the partial frame. The next accepted pixel is treated as (0,0).
  - reset has priority over i_in_valid in the same cycle; that pixel is dropped.
- Counter wrap and next-frame pixel acceptance on consecutive cycles must produce no spurious window. Row 0 of the new frame never emits.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- IX=IY=5, KX=KY=3, CI=1, I_F_BW=8, pixel = row*5+col, streamed continuously -> 9 pulses. First window is 0,1,2,5,6,7,10,11,12 (kx fastest), one cycle after pixel 12 is accepted. Last window is 12..24 in the same pattern, with o_ot_last=1 and o_frame_done=1.
- Same frame with i_in_valid toggling 1,0,0,1,... -> identical 9 windows in order. No pulse ever occurs on a cycle that does not follow an accepting cycle.
- Two back-to-back frames, second frame pixel = 100+row*5+col -> 18 windows total. Second-frame first window is 100,101,102,105,106,107,110,111,112, containing no first-frame values.
- Reset asserted after 13 pixels, then a full frame -> no pulse while reset is high. The post-reset output matches the first scenario exactly.
- CI=2, ch0 = row*5+col, ch1 = -(row*5+col) -> first window has ch0 field 0..12 pattern and ch1 field 0,-1,-2,-5,-6,-7,-10,-11,-12 at the bit offsets defined in Operation.
- Edge geometry IX=KX=3, IY=KY=3 -> exactly one window, after pixel 8, with o_ot_last=1.
